bcd_timer_ctrl: RTL
===================

Name: bcd_timer_ctrl

Overview:
- Sequencer for a cascade of mod-10 counter digits, forming a programmable DIGITS-digit BCD countdown timer.
- Owns the run/pause/done state machine, the clock prescaler and the borrow chain between digits.
- Each digit is a decade counter with enable, load and borrow, instantiated as a sub-module.
- Sits between control logic (start/pause/clear/load strobes) and display/interrupt consumers (digits, done).

Parameters:
- DIGITS, 4, number of BCD digits; value width is 4*DIGITS.
- PRESCALE, 10, clk cycles per count tick; legal range 1..1023.

Ports:
- clk  input  1  rising-edge clock
- res  input  1  reset; asynchronous, active-high
- start  input  1  begin/resume counting (level sampled per cycle)
- pause  input  1  hold count while in RUN
- clear  input  1  synchronous abort to IDLE, value zeroed
- load  input  1  load load_val into digits
- load_val  input  4*DIGITS  BCD preset; digit 0 in [3:0]
- digits  output  4*DIGITS  current BCD value
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- busy  output  1  high in RUN or PAUSE
- tick  output  1  one-cycle pulse on each decrement
- done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, res=1): digits=0, state=IDLE, prescale count=0; busy, tick and done all 0. Release takes effect at the next clk edge.
- All other updates occur on the rising edge of clk.
- Strobe priority each cycle: clear > load > start > pause.
- clear, any state: next state IDLE, digits=0, prescale=0. No done pulse.
- load:
  - Accepted only in IDLE or DONE; ignored in RUN and PAUSE.
  - Each 4-bit field >9 is saturated to 9 on load.
  - State goes to IDLE.
- IDLE + start:
  - If digits==0: go to DONE and pulse done the following cycle.
  - Otherwise: go to RUN with prescale=0.
- RUN:
  - Prescale increments each cycle. At PRESCALE-1 it wraps to 0, tick=1 in that cycle, and the value decrements by 1 at that edge.
  - BCD decrement: digit 0 decrements; a digit at 0 wraps to 9 and borrows from the next digit. Example: 0100 -> 0099.
  - The tick that takes the value from 1 to 0 also moves state to DONE at the same edge.
- RUN + pause (start low): go to PAUSE. Prescale and digits hold; no tick.
- PAUSE + start: return to RUN, resuming from the held prescale (no restart).
- RUN with pause and start both high: stay in RUN (start wins).
- DONE:
  - done=1 for exactly the first cycle in DONE. Digits remain 0.
  - start re-enters DONE without a new pulse.
  - load reloads the value and goes to IDLE.
- PRESCALE=1: tick every cycle in RUN.
- Value never underflows; a tick at 0 is impossible by construction.
- tick is registered combinationally from the prescale compare; no other output is combinational.

Decomposition:
- Shared package bcd_timer_pkg holds:
  - state encoding constants S_IDLE=2'b00, S_RUN=2'b01, S_PAUSE=2'b10, S_DONE=2'b11;
  - BCD_MAX=4'd9.
- Sub-module bcd_digit holds one decade-counter digit with ports clk, res, en, ld, d[3:0], q[3:0], bout.
  - bout is asserted when en=1 and q==0.
  - The controller generates DIGITS instances, chaining en of digit i+1 from the AND of lower-digit bout signals.

Test Plan:
- Reset: res pulse mid-RUN with digits=0x0042 -> digits=0x0000, state=00 and busy=0 immediately, without waiting for clk.
- Basic countdown (PRESCALE=4): load 0x0003, start -> tick every 4 cycles; digits 0003 -> 0002 -> 0001 -> 0000. On the 0001->0000 tick, state=11; done high for exactly 1 cycle, 12 cycles after RUN entry.
- Borrow chain (PRESCALE=1): load 0x1000, start -> next ticks give 0999, 0998. Load 0x0A5F -> digits 0x0959.
- Pause/resume (PRESCALE=4): pause asserted after 2 cycles of RUN with value 0005, held 10 cycles -> no tick, digits stay 0005. Start -> first tick 2 cycles later.
- Priority: clear and load together in DONE -> IDLE, digits=0. Load in RUN -> ignored. Start with value 0 -> DONE plus single done pulse.
- Clear mid-RUN -> IDLE, digits=0, done stays 0. A second start in DONE -> no extra done pulse.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding and BCD helpers.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp a raw nibble into the legal BCD range.
    function automatic logic [3:0] bcd_sat(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_timer_ctrl_digit.sv
// One decade down-counter digit with load and borrow-out.
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       bout
);

    assign bout = en && (q == 4'd0);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Programmable DIGITS-digit BCD countdown timer: run/pause/done sequencing,
// tick prescaler and the borrow chain across the digit counters.
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   digits,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  tick,
    output logic                  done
);

    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    state_t          state_q, state_nxt;
    logic [PW-1:0]   presc_q, presc_nxt;
    logic            busy_q, done_q;
    logic            dig_ld;
    logic [VW-1:0]   dig_d;
    logic [DIGITS-1:0] en_chain;
    logic [DIGITS-1:0] bout;
    logic            val_zero, val_one;
    logic            borrow_unused;

    assign val_zero = (digits == '0);
    assign val_one  = (digits == VW'(1));

    // Next-state, prescaler and digit-load decode.
    always_comb begin
        state_nxt = state_q;
        presc_nxt = presc_q;
        tick      = 1'b0;
        dig_ld    = 1'b0;
        dig_d     = '0;
        if (clear) begin
            state_nxt = S_IDLE;
            presc_nxt = '0;
            dig_ld    = 1'b1;
        end else if (load && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_nxt = S_IDLE;
            presc_nxt = '0;
            dig_ld    = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                dig_d[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        presc_nxt = '0;
                        state_nxt = val_zero ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause && !start) begin
                        state_nxt = S_PAUSE;
                    end else if (presc_q == P_LAST) begin
                        presc_nxt = '0;
                        tick      = 1'b1;
                        if (val_one) begin
                            state_nxt = S_DONE;
                        end
                    end else begin
                        presc_nxt = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            presc_q <= presc_nxt;
            busy_q  <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
            done_q  <= (state_nxt == S_DONE) && (state_q != S_DONE);
        end
    end

    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // Borrow chain: a digit decrements only when every lower digit wraps.
    assign en_chain[0] = tick;

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        bcd_digit u_digit (
            .clk  (clk),
            .res  (res),
            .en   (en_chain[i]),
            .ld   (dig_ld),
            .d    (dig_d[4*i +: 4]),
            .q    (digits[4*i +: 4]),
            .bout (bout[i])
        );
        if (i < int'(DIGITS) - 1) begin : g_chain
            assign en_chain[i+1] = bout[i];
        end
    end

    // The top digit's borrow would mean underflow, which the FSM never allows.
    assign borrow_unused = bout[DIGITS-1];

endmodule
